// File: rtl/execute_hilo.sv
// execute_hilo: MIPS execute stage with a registered decode bundle, a
// single-cycle ALU, HI/LO registers, an iterative multiply/divide unit and
// store byte-strobe generation. e_busy asks upstream to hold while MD runs.
module execute_hilo #(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] E_pc,
  input  logic [W-1:0] E_val1,
  input  logic [W-1:0] E_val2,
  input  logic [W-1:0] E_valt,
  input  logic [5:0]   E_icode,
  input  logic [5:0]   E_acode,
  input  logic [4:0]   E_dst,
  input  logic [4:0]   E_sa,
  input  logic         E_bubble,
  output logic [W-1:0] e_pc,
  output logic [W-1:0] e_val3,
  output logic [W-1:0] e_valt,
  output logic [5:0]   e_icode,
  output logic [5:0]   e_acode,
  output logic [4:0]   e_dst,
  output logic [3:0]   e_req,
  output logic         e_busy
);
  localparam int SHW     = $clog2(W);
  localparam int LAT_MAX = (W + 1 > MUL_CYCLES) ? W + 1 : MUL_CYCLES;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  // SPECIAL function codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} md_state_t;

  // Bundle register
  logic [W-1:0] pc_r, val1_r, val2_r, valt_r;
  logic [5:0]   icode_r, acode_r;
  logic [4:0]   dst_r, sa_r;

  // HI/LO and multiply/divide state
  logic [W-1:0]     hi_r, lo_r;
  md_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     opa_r;      // multiplicand, or dividend magnitude shifting into quotient
  logic [W-1:0]     opb_r;      // multiplier, or divisor magnitude
  logic [W-1:0]     rem_r;      // partial remainder
  logic [W-1:0]     dvd_r;      // original dividend, returned in HI on divide by zero
  logic             is_div_r, is_signed_r, neg_q_r, neg_r_r, dvs_zero_r;

  logic             is_md_s, is_mthi_s, is_mtlo_s, busy_s, md_last_s;
  logic [SHW-1:0]   sh_sa_s, sh_v_s;
  logic [W-1:0]     alu_s, valt_s;
  logic [3:0]       req_s;
  logic [W:0]       div_sh_s;
  logic             div_ge_s;
  logic [W-1:0]     div_sub_s, div_rem_s, div_quo_s;
  logic [2*W-1:0]   mul_a_s, mul_b_s, prod_s;
  logic [W-1:0]     md_hi_s, md_lo_s;

  assign is_md_s   = (icode_r == OP_SPECIAL) &&
                     (acode_r == FN_MULT || acode_r == FN_MULTU ||
                      acode_r == FN_DIV  || acode_r == FN_DIVU);
  assign is_mthi_s = (icode_r == OP_SPECIAL) && (acode_r == FN_MTHI);
  assign is_mtlo_s = (icode_r == OP_SPECIAL) && (acode_r == FN_MTLO);
  // IDLE with an MD op counts as the first busy cycle; RUN covers the rest.
  assign busy_s    = ((state_r == ST_IDLE) && is_md_s) || (state_r == ST_RUN);
  assign md_last_s = (state_r == ST_RUN) && (cnt_r == CNT_W'(1));
  assign sh_sa_s   = SHW'(sa_r);
  assign sh_v_s    = val1_r[SHW-1:0];

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  assign div_sh_s  = {rem_r, opa_r[W-1]};
  assign div_ge_s  = (div_sh_s >= {1'b0, opb_r});
  assign div_sub_s = div_sh_s[W-1:0] - opb_r;
  assign div_rem_s = div_ge_s ? div_sub_s : div_sh_s[W-1:0];
  assign div_quo_s = {opa_r[W-2:0], div_ge_s};

  // Extending to 2W bits first makes one unsigned multiply serve both signednesses.
  assign mul_a_s = is_signed_r ? {{W{opa_r[W-1]}}, opa_r} : {{W{1'b0}}, opa_r};
  assign mul_b_s = is_signed_r ? {{W{opb_r[W-1]}}, opb_r} : {{W{1'b0}}, opb_r};
  assign prod_s  = mul_a_s * mul_b_s;

  // Final MD result from the last step, with sign fix-up and divide-by-zero override.
  always_comb begin
    md_hi_s = '0;
    md_lo_s = '0;
    if (!is_div_r) begin
      md_hi_s = prod_s[2*W-1:W];
      md_lo_s = prod_s[W-1:0];
    end else if (dvs_zero_r) begin
      md_hi_s = dvd_r;
      md_lo_s = '1;
    end else begin
      md_lo_s = neg_q_r ? -div_quo_s : div_quo_s;
      md_hi_s = neg_r_r ? -div_rem_s : div_rem_s;
    end
  end

  // Capture the decode bundle unless stalled; a bubble loads zeros.
  always_ff @(posedge clk) begin
    if (reset || (!busy_s && E_bubble)) begin
      pc_r    <= '0;
      val1_r  <= '0;
      val2_r  <= '0;
      valt_r  <= '0;
      icode_r <= 6'h00;
      acode_r <= 6'h00;
      dst_r   <= 5'd0;
      sa_r    <= 5'd0;
    end else if (!busy_s) begin
      pc_r    <= E_pc;
      val1_r  <= E_val1;
      val2_r  <= E_val2;
      valt_r  <= E_valt;
      icode_r <= E_icode;
      acode_r <= E_acode;
      dst_r   <= E_dst;
      sa_r    <= E_sa;
    end
  end

  // Multiply/divide sequencer: latch operands in IDLE, iterate in RUN, one DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      opa_r       <= '0;
      opb_r       <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      is_div_r    <= 1'b0;
      is_signed_r <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dvs_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_md_s) begin
            is_div_r    <= (acode_r == FN_DIV) || (acode_r == FN_DIVU);
            is_signed_r <= (acode_r == FN_MULT) || (acode_r == FN_DIV);
            rem_r       <= '0;
            dvd_r       <= val1_r;
            dvs_zero_r  <= (val2_r == '0);
            if (acode_r == FN_DIV) begin
              opa_r   <= val1_r[W-1] ? -val1_r : val1_r;
              opb_r   <= val2_r[W-1] ? -val2_r : val2_r;
              neg_q_r <= val1_r[W-1] ^ val2_r[W-1];
              neg_r_r <= val1_r[W-1];
            end else begin
              opa_r   <= val1_r;
              opb_r   <= val2_r;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end
            if ((acode_r == FN_DIV) || (acode_r == FN_DIVU)) begin
              cnt_r <= CNT_W'(W);
            end else begin
              cnt_r <= CNT_W'(MUL_CYCLES - 1);
            end
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (is_div_r) begin
            opa_r <= div_quo_s;
            rem_r <= div_rem_s;
          end
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // HI/LO: MD results on the final step, MTHI/MTLO at the end of their cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (md_last_s) begin
      hi_r <= md_hi_s;
      lo_r <= md_lo_s;
    end else if (!busy_s && is_mthi_s) begin
      hi_r <= val1_r;
    end else if (!busy_s && is_mtlo_s) begin
      lo_r <= val1_r;
    end
  end

  // Single-cycle ALU result; loads/stores produce their effective address.
  always_comb begin
    alu_s = '0;
    if (icode_r == OP_SPECIAL) begin
      case (acode_r)
        FN_SLL:          alu_s = val2_r << sh_sa_s;
        FN_SRL:          alu_s = val2_r >> sh_sa_s;
        FN_SRA:          alu_s = $signed(val2_r) >>> sh_sa_s;
        FN_SLLV:         alu_s = val2_r << sh_v_s;
        FN_SRLV:         alu_s = val2_r >> sh_v_s;
        FN_SRAV:         alu_s = $signed(val2_r) >>> sh_v_s;
        FN_MFHI:         alu_s = hi_r;
        FN_MFLO:         alu_s = lo_r;
        FN_ADD, FN_ADDU: alu_s = val1_r + val2_r;
        FN_SUB, FN_SUBU: alu_s = val1_r - val2_r;
        FN_AND:          alu_s = val1_r & val2_r;
        FN_OR:           alu_s = val1_r | val2_r;
        FN_XOR:          alu_s = val1_r ^ val2_r;
        FN_NOR:          alu_s = ~(val1_r | val2_r);
        FN_SLT:          alu_s = W'($signed(val1_r) < $signed(val2_r));
        FN_SLTU:         alu_s = W'(val1_r < val2_r);
        default:         alu_s = '0;
      endcase
    end else begin
      case (icode_r)
        OP_ADDI, OP_ADDIU: alu_s = val1_r + val2_r;
        OP_SLTI:           alu_s = W'($signed(val1_r) < $signed(val2_r));
        OP_SLTIU:          alu_s = W'(val1_r < val2_r);
        OP_ANDI:           alu_s = val1_r & val2_r;
        OP_ORI:            alu_s = val1_r | val2_r;
        OP_XORI:           alu_s = val1_r ^ val2_r;
        OP_LUI:            alu_s = {val2_r[W-17:0], 16'h0000};
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW: alu_s = val1_r + val2_r;
        default:           alu_s = '0;
      endcase
    end
  end

  // Store strobes and lane-replicated store data from the effective address.
  always_comb begin
    req_s  = 4'b0000;
    valt_s = valt_r;
    case (icode_r)
      OP_SW: begin
        req_s  = 4'b1111;
        valt_s = valt_r;
      end
      OP_SH: begin
        req_s  = alu_s[1] ? 4'b1100 : 4'b0011;
        valt_s = {(W/16){valt_r[15:0]}};
      end
      OP_SB: begin
        req_s  = 4'b0001 << alu_s[1:0];
        valt_s = {(W/8){valt_r[7:0]}};
      end
      default: begin
        req_s  = 4'b0000;
        valt_s = valt_r;
      end
    endcase
  end

  // Present the bundle, or a zero bubble while stalled.
  always_comb begin
    e_pc    = '0;
    e_val3  = '0;
    e_valt  = '0;
    e_icode = 6'h00;
    e_acode = 6'h00;
    e_dst   = 5'd0;
    e_req   = 4'b0000;
    e_busy  = busy_s;
    if (busy_s) begin
      e_pc    = '0;
      e_val3  = '0;
      e_valt  = '0;
      e_icode = 6'h00;
      e_acode = 6'h00;
      e_dst   = 5'd0;
      e_req   = 4'b0000;
    end else begin
      e_pc    = pc_r;
      e_val3  = alu_s;
      e_valt  = valt_s;
      e_icode = icode_r;
      e_acode = acode_r;
      e_dst   = dst_r;
      e_req   = req_s;
    end
  end
endmodule

// File: tb/tb_execute_hilo.sv
// Testbench for execute_hilo: directed vector table, hand sequences for the
// multi-cycle corners, and randomized ops against a behavioural model.
module tb_execute_hilo;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_pc, E_val1, E_val2, E_valt;
  logic [5:0]  E_icode, E_acode;
  logic [4:0]  E_dst, E_sa;
  logic        E_bubble;
  logic [31:0] e_pc, e_val3, e_valt;
  logic [5:0]  e_icode, e_acode;
  logic [4:0]  e_dst;
  logic [3:0]  e_req;
  logic        e_busy;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] SPC = 6'h00;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  execute_hilo #(.W(32), .MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .E_pc(E_pc), .E_val1(E_val1), .E_val2(E_val2), .E_valt(E_valt),
    .E_icode(E_icode), .E_acode(E_acode), .E_dst(E_dst), .E_sa(E_sa),
    .E_bubble(E_bubble),
    .e_pc(e_pc), .e_val3(e_val3), .e_valt(e_valt),
    .e_icode(e_icode), .e_acode(e_acode), .e_dst(e_dst),
    .e_req(e_req), .e_busy(e_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ic, ac;
    logic [31:0] v1, v2, vt;
    logic [4:0] sa;
    logic [31:0] x3;
    logic [3:0] xreq;
    logic [31:0] xvt;
  } vec_t;

  typedef struct { logic [5:0] ic, ac; } op_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ic, input logic [5:0] ac, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] vt, input logic [4:0] sa,
                       input logic [4:0] dst, input logic [31:0] pc, input logic bub);
    E_icode = ic; E_acode = ac; E_val1 = v1; E_val2 = v2; E_valt = vt;
    E_sa = sa; E_dst = dst; E_pc = pc; E_bubble = bub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the single-cycle result
  function automatic logic [31:0] ref_val3(input logic [5:0] ic, input logic [5:0] ac,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sa);
    if (ic == SPC) begin
      case (ac)
        FN_SLL:  return b << sa;
        FN_SRL:  return b >> sa;
        FN_SRA:  return $signed(b) >>> sa;
        FN_SLLV: return b << a[4:0];
        FN_SRLV: return b >> a[4:0];
        FN_SRAV: return $signed(b) >>> a[4:0];
        FN_ADD, FN_ADDU: return a + b;
        FN_SUB, FN_SUBU: return a - b;
        FN_AND:  return a & b;
        FN_OR:   return a | b;
        FN_XOR:  return a ^ b;
        FN_NOR:  return ~(a | b);
        FN_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        FN_SLTU: return (a < b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    case (ic)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SB, OP_SH, OP_SW: return a + b;
      OP_SLTI:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      OP_ANDI:  return a & b;
      OP_ORI:   return a | b;
      OP_XORI:  return a ^ b;
      OP_LUI:   return b * 32'd65536;
      default:  return 32'd0;
    endcase
  endfunction

  // Behavioural model of store lanes
  task automatic ref_store(input logic [5:0] ic, input logic [31:0] addr, input logic [31:0] vt,
                           output logic [3:0] req, output logic [31:0] vo);
    int lane;
    lane = int'(addr % 32'd4);
    req = 4'b0000;
    vo = vt;
    if (ic == OP_SW) begin
      req = 4'b1111;
    end else if (ic == OP_SH) begin
      req = (lane >= 2) ? 4'b1100 : 4'b0011;
      vo = vt[15:0] * 32'h0001_0001;
    end else if (ic == OP_SB) begin
      req = 4'(1 << lane);
      vo = vt[7:0] * 32'h0101_0101;
    end
  endtask

  // Behavioural model of multiply/divide
  task automatic ref_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint sa_, sb_, q, r;
    logic [63:0] p;
    sa_ = longint'($signed(a));
    sb_ = longint'($signed(b));
    hi = 32'd0; lo = 32'd0;
    if (op == FN_MULT) begin
      p = sa_ * sb_;
      hi = p[63:32]; lo = p[31:0];
    end else if (op == FN_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF;
    end else if (op == FN_DIV) begin
      q = sa_ / sb_; r = sa_ % sb_;
      lo = q[31:0]; hi = r[31:0];
    end else begin
      lo = a / b; hi = a % b;
    end
  endtask

  task automatic start_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(SPC, op, a, b, $urandom, 5'd0, 5'd0, $urandom, 1'b0);
    tick();
  endtask

  // Count busy cycles while throwing junk (and bubbles) at the held register.
  task automatic wait_busy(input string name, input int exp_lat, input logic [5:0] op);
    int n;
    n = 1;
    chk({name, "_busy0"}, {31'd0, e_busy}, 32'd1);
    drive(6'($urandom), 6'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
          5'($urandom), $urandom, 1'($urandom));
    tick();
    while (e_busy === 1'b1 && n < 100) begin
      chk({name, "_bubble_out"}, e_val3 | {26'd0, e_icode}, 32'd0);
      drive(6'($urandom), 6'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
            5'($urandom), $urandom, 1'($urandom));
      n++;
      tick();
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_held_acode"}, {26'd0, e_acode}, {26'd0, op});
    chk({name, "_req"}, {28'd0, e_req}, 32'd0);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    drive(SPC, FN_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 32'd0, 1'b0);
    tick();
    chk({name, "_hi"}, e_val3, hi);
    drive(SPC, FN_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 32'd0, 1'b0);
    tick();
    chk({name, "_lo"}, e_val3, lo);
    drive(SPC, FN_SLL, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 1'b1);
  endtask

  vec_t vecs [15];
  op_t  ops [$];

  initial begin
    logic [31:0] a, b, vt, pc, x3, xvt, hi, lo;
    logic [3:0] xreq;
    logic [4:0] sa, dst;
    logic [5:0] op;
    op_t o;

    vecs[0]  = '{SPC, FN_ADDU, 32'd5, 32'd7, 32'd0, 5'd0, 32'd12, 4'b0000, 32'd0};
    vecs[1]  = '{SPC, FN_SUBU, 32'd5, 32'd7, 32'd0, 5'd0, 32'hFFFF_FFFE, 4'b0000, 32'd0};
    vecs[2]  = '{SPC, FN_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd1, 4'b0000, 32'd0};
    vecs[3]  = '{SPC, FN_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd0, 4'b0000, 32'd0};
    vecs[4]  = '{SPC, FN_SRA, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 4'b0000, 32'd0};
    vecs[5]  = '{SPC, FN_SRL, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 4'b0000, 32'd0};
    vecs[6]  = '{SPC, FN_SLL, 32'd0, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 4'b0000, 32'd0};
    vecs[7]  = '{SPC, FN_NOR, 32'd0, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 4'b0000, 32'd0};
    vecs[8]  = '{OP_LUI, 6'h00, 32'd0, 32'h0000_1234, 32'd0, 5'd0, 32'h1234_0000, 4'b0000, 32'd0};
    vecs[9]  = '{OP_SB, 6'h00, 32'h1000, 32'd2, 32'h0000_00AB, 5'd0, 32'h1002, 4'b0100, 32'hABAB_ABAB};
    vecs[10] = '{OP_SH, 6'h00, 32'h1000, 32'd2, 32'h0000_BEEF, 5'd0, 32'h1002, 4'b1100, 32'hBEEF_BEEF};
    vecs[11] = '{OP_SW, 6'h00, 32'h1000, 32'd4, 32'hDEAD_BEEF, 5'd0, 32'h1004, 4'b1111, 32'hDEAD_BEEF};
    vecs[12] = '{OP_SB, 6'h00, 32'h1000, 32'd3, 32'h0000_0012, 5'd0, 32'h1003, 4'b1000, 32'h1212_1212};
    vecs[13] = '{OP_SH, 6'h00, 32'h1000, 32'd1, 32'h0000_5678, 5'd0, 32'h1001, 4'b0011, 32'h5678_5678};
    vecs[14] = '{SPC, 6'h3F, 32'd9, 32'd9, 32'h1122_3344, 5'd0, 32'd0, 4'b0000, 32'h1122_3344};

    foreach (vecs[i]) if (i < 9) ops.push_back('{vecs[i].ic, vecs[i].ac});
    ops.push_back('{SPC, FN_SLLV}); ops.push_back('{SPC, FN_SRLV}); ops.push_back('{SPC, FN_SRAV});
    ops.push_back('{SPC, FN_ADD});  ops.push_back('{SPC, FN_AND});  ops.push_back('{SPC, FN_OR});
    ops.push_back('{SPC, FN_XOR});  ops.push_back('{OP_ADDI, 6'h00}); ops.push_back('{OP_SLTI, 6'h00});
    ops.push_back('{OP_SLTIU, 6'h00}); ops.push_back('{OP_ANDI, 6'h00}); ops.push_back('{OP_ORI, 6'h00});
    ops.push_back('{OP_XORI, 6'h00}); ops.push_back('{OP_LW, 6'h00}); ops.push_back('{OP_SB, 6'h00});
    ops.push_back('{OP_SH, 6'h00}); ops.push_back('{OP_SW, 6'h00});

    // Reset with junk on the inputs: every output must read zero.
    reset = 1'b1;
    drive(SPC, FN_ADDU, $urandom, $urandom, $urandom, 5'd7, 5'd9, $urandom, 1'b0);
    tick(); tick();
    chk("rst_val3", e_val3, 32'd0);
    chk("rst_pc", e_pc, 32'd0);
    chk("rst_valt", e_valt, 32'd0);
    chk("rst_ctrl", {9'd0, e_icode, e_acode, e_dst, e_req, e_busy}, 32'd0);
    reset = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      pc = $urandom;
      dst = 5'($urandom);
      drive(vecs[i].ic, vecs[i].ac, vecs[i].v1, vecs[i].v2, vecs[i].vt, vecs[i].sa, dst, pc, 1'b0);
      tick();
      chk($sformatf("vec%0d_val3", i), e_val3, vecs[i].x3);
      chk($sformatf("vec%0d_req", i), {28'd0, e_req}, {28'd0, vecs[i].xreq});
      chk($sformatf("vec%0d_valt", i), e_valt, vecs[i].xvt);
      chk($sformatf("vec%0d_pc", i), e_pc, pc);
      chk($sformatf("vec%0d_dst", i), {27'd0, e_dst}, {27'd0, dst});
    end

    // Bubble when not busy loads zeros
    drive(OP_SW, 6'h05, 32'h1000, 32'd4, 32'hFFFF_FFFF, 5'd3, 5'd7, 32'h4444, 1'b1);
    tick();
    chk("bubble_out", e_val3 | e_pc | e_valt | {22'd0, e_icode, e_req}, 32'd0);

    // MTHI/MTLO visible to the next instruction
    drive(SPC, FN_MTHI, 32'h0000_0055, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    tick();
    drive(SPC, FN_MTLO, 32'h0000_00AA, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    tick();
    read_hilo("mt", 32'h0000_0055, 32'h0000_00AA);

    // Directed multiply/divide corners
    start_md(FN_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_busy("mult", 3, FN_MULT);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    start_md(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy("div", 33, FN_DIV);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_md(FN_DIVU, 32'd9, 32'd0);
    wait_busy("divu0", 33, FN_DIVU);
    read_hilo("divu0", 32'd9, 32'hFFFF_FFFF);
    start_md(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy("divovf", 33, FN_DIV);
    read_hilo("divovf", 32'd0, 32'h8000_0000);

    // Back-to-back: second MD captured in the first one's DONE cycle
    start_md(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy("b2b_a", 3, FN_MULTU);
    start_md(FN_DIVU, 32'd100, 32'd7);
    wait_busy("b2b_b", 33, FN_DIVU);
    read_hilo("b2b", 32'd2, 32'd14);

    // Reset in the 10th cycle of a DIV aborts it and clears HI/LO
    start_md(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) tick();
    chk("rstmid_busy_before", {31'd0, e_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy_after", {31'd0, e_busy}, 32'd0);
    chk("rstmid_acode", {26'd0, e_acode}, 32'd0);
    read_hilo("rstmid", 32'd0, 32'd0);

    // Randomized single-cycle ops
    for (int k = 0; k < 60; k++) begin
      o = ops[$urandom_range(0, ops.size() - 1)];
      a = $urandom; b = $urandom; vt = $urandom; sa = 5'($urandom);
      pc = $urandom; dst = 5'($urandom);
      drive(o.ic, o.ac, a, b, vt, sa, dst, pc, 1'b0);
      tick();
      x3 = ref_val3(o.ic, o.ac, a, b, sa);
      ref_store(o.ic, x3, vt, xreq, xvt);
      chk($sformatf("rnd%0d_val3", k), e_val3, x3);
      chk($sformatf("rnd%0d_req", k), {28'd0, e_req}, {28'd0, xreq});
      chk($sformatf("rnd%0d_valt", k), e_valt, xvt);
    end

    // Randomized multiply/divide with edge operands mixed in
    for (int k = 0; k < 16; k++) begin
      op = 6'(6'h18 + 6'($urandom_range(0, 3)));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      ref_md(op, a, b, hi, lo);
      start_md(op, a, b);
      wait_busy($sformatf("rmd%0d", k), (op == FN_DIV || op == FN_DIVU) ? 33 : 3, op);
      read_hilo($sformatf("rmd%0d", k), hi, lo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_hilo.md
# execute_hilo

Parametrised MIPS execute stage that registers the decode-to-execute bundle and evaluates single-cycle ALU ops, as the successor to the current execute stage. It adds HI/LO registers, iterative MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO, and SB/SH/SW byte-strobe generation. It sits between decode and memory and tells upstream to hold through a busy handshake while a multiply or divide is in flight.

## Interface
- W, 32: datapath width; all value ports and HI/LO are W bits.
- MUL_CYCLES, 3: busy cycles for MULT/MULTU; legal range is 2 or more.
- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- E_pc, E_val1, E_val2, E_valt  in  W each  pc, operand 1, operand 2/immediate, store data.
- E_icode, E_acode  in  6 each  opcode and SPECIAL funct, using the shared header encodings.
- E_dst, E_sa  in  5 each  destination register and shift amount.
- E_bubble  in  1  load an all-zero bundle instead of E_*.
- e_pc, e_val3, e_valt  out  W each  pc, result, and lane-aligned store data.
- e_icode, e_acode  out  6 each  opcode and funct.
- e_dst  out  5  destination register.
- e_req  out  4  byte write strobes.
- e_busy  out  1  the held bundle is stalled; upstream must hold its outputs.

## Operation
- Bundle register
  - Reset or E_bubble (when not busy) loads all zeros.
  - Otherwise it captures E_* when e_busy=0.
  - While e_busy=1 it holds, and E_bubble is ignored.
- Single-cycle ALU: the current set of I-type and SPECIAL ops is unchanged.
  - The add, logic, slt and shift family behave as today.
  - Shifts use the low log2(W) bits of e_sa; unknown codes give e_val3=0.
- HI/LO access
  - MFHI/MFLO: e_val3 = HI/LO.
  - MTHI/MTLO write val1 to HI/LO at the edge that ends their register cycle, so the next instruction reads the new value.
- Multiply/divide FSM with states IDLE, RUN, DONE
  - IDLE, with MULT/MULTU/DIV/DIVU in the register: e_busy=1. Load the counter with LAT-1 and latch operands (magnitudes for signed divide). Go to RUN.
  - LAT is MUL_CYCLES for multiplies and W+1 for divides.
  - RUN: e_busy=1; the counter decrements each cycle. Divide is radix-2 restoring, one quotient bit per cycle.
  - At count 0: write HI/LO at that edge and go to DONE.
  - DONE: e_busy=0; the register accepts the next bundle; go to IDLE.
- Multiply/divide results
  - MULT/MULTU: {HI,LO} = the 2W-bit signed/unsigned product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend, same latency.
  - Signed overflow (min/-1): LO = min, HI = 0.
- Outputs while e_busy=1: forced to zero (a bubble) so the memory stage sees no repeats.
- Outputs in DONE: the bundle is presented with e_dst and e_val3 taken from the bundle register as for any other op. MD ops have e_dst=0 and carry no store strobe.
- Store strobes (addr = e_val3)
  - SW: e_req=1111 and e_valt is passed through.
  - SH: e_req=1100 if addr[1], else 0011; e_valt = the halfword replicated to both halves; addr[0] is ignored.
  - SB: e_req = 1 shifted left by addr[1:0]; e_valt = the byte replicated to all four lanes.
  - All other ops: e_req=0000.
- Reset mid-op: aborts any MD op. The FSM goes to IDLE, HI=LO=0, and the register is zero.

## Timing
- Reset values: every output 0; HI=LO=0; FSM in IDLE.
- Latency
  - ALU, MF* and store ops: result is combinational from the register, one cycle after capture.
  - MD op held in the register: 1 + LAT cycles total, with e_busy high for the first LAT of them.
- Back-to-back MD ops
  - The second is captured in the DONE cycle.
  - It starts its own IDLE cycle the next cycle, with no extra gap.
- An MD op directly followed by MFHI/MFLO: MFHI is captured in DONE and reads the new HI the next cycle.
- e_busy is combinational from the FSM state and the registered icode/acode; it does not depend on E_* inputs.

## Test plan
- Reset, then ADDU 5+7 -> e_val3=12 one cycle after capture; all outputs 0 during reset.
- MULT 0xFFFFFFFF × 2 (signed), MUL_CYCLES=3 -> e_busy high exactly 3 cycles; then MFHI gives 0xFFFFFFFF and MFLO gives 0xFFFFFFFE.
- DIV -7 / 2 -> e_busy high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 9 / 0 -> LO=0xFFFFFFFF, HI=9; also DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- SB data 0xAB at addr 0x1002 -> e_req=0100, e_valt=0xABABABAB; SH at addr 0x1002 -> e_req=1100.
- Reset asserted in the 10th cycle of a DIV -> e_busy=0 and HI=LO=0 next cycle; E_bubble during busy -> register unchanged.
